// File: rtl/autosa_pdp_rdma_pkg.sv
// Shared encodings for the PDP RDMA ping-pong group scheduler.
// Status values are what the single-register block reads back.
package autosa_pdp_rdma_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  typedef enum logic [1:0] {
    E_IDLE   = 2'd0,
    E_LAUNCH = 2'd1,
    E_BUSY   = 2'd2,
    E_SWITCH = 2'd3
  } eng_state_e;

  function automatic logic [1:0] grp_onehot(input logic grp);
    return grp ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/autosa_pdp_rdma_grp_state.sv
// Per-group life-cycle register (IDLE -> PENDING -> RUNNING -> IDLE).
// Finish wins over everything so a set landing in the switch cycle is dropped.
module autosa_pdp_rdma_grp_state
  import autosa_pdp_rdma_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic       launch_i,
  input  logic       finish_i,
  output logic [1:0] status_o,
  output logic       busy_wr_o
);

  logic [1:0] status_q, status_d;

  always_comb begin
    status_d = status_q;
    if (finish_i) begin
      status_d = ST_IDLE;
    end else if (launch_i) begin
      status_d = ST_RUNNING;
    end else if (set_i && (status_q == ST_IDLE)) begin
      status_d = ST_PENDING;
    end else begin
      status_d = status_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q <= ST_IDLE;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o  = status_q;
  assign busy_wr_o = set_i && (status_q == ST_RUNNING);

endmodule

// File: rtl/autosa_pdp_rdma_group_ctrl.sv
// Ping-pong launch scheduler for the two PDP RDMA register groups.
// Optional cycle counter built when AUTOSA_PDP_RDMA_PERF_EN is defined.
module autosa_pdp_rdma_group_ctrl
  import autosa_pdp_rdma_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              autosa_core_clk,
  input  logic              autosa_core_rst,
  input  logic [1:0]        op_en_set,
  input  logic              start_ready,
  input  logic              op_done,
  output logic              consumer,
  output logic [1:0]        status_0,
  output logic [1:0]        status_1,
  output logic              start_valid,
  output logic              start_group,
  output logic [1:0]        op_en_clr,
  output logic [1:0]        done_intr,
  output logic              err_busy_wr,
  output logic [PERF_W-1:0] perf_cycles
);

  eng_state_e state_q, state_d;
  logic       consumer_q;
  logic       start_valid_q, start_group_q;
  logic [1:0] op_en_clr_q, done_intr_q;
  logic       err_busy_q;
  logic [1:0] grp_status_s [2];
  logic [1:0] busy_wr_s;
  logic [1:0] grp_sel_s;
  logic [1:0] cons_status_s;
  logic       launch_s, finish_s;

  assign grp_sel_s     = grp_onehot(consumer_q);
  assign cons_status_s = consumer_q ? grp_status_s[1] : grp_status_s[0];
  assign launch_s      = (state_q == E_LAUNCH) && start_ready;
  assign finish_s      = (state_q == E_SWITCH);

  for (genvar g = 0; g < 2; g++) begin : g_grp
    autosa_pdp_rdma_grp_state u_grp (
      .clk_i     (autosa_core_clk),
      .rst_i     (autosa_core_rst),
      .set_i     (op_en_set[g]),
      .launch_i  (launch_s && grp_sel_s[g]),
      .finish_i  (finish_s && grp_sel_s[g]),
      .status_o  (grp_status_s[g]),
      .busy_wr_o (busy_wr_s[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      E_IDLE:   state_d = (cons_status_s == ST_PENDING) ? E_LAUNCH : E_IDLE;
      E_LAUNCH: state_d = start_ready ? E_BUSY : E_LAUNCH;
      E_BUSY:   state_d = op_done ? E_SWITCH : E_BUSY;
      E_SWITCH: state_d = E_IDLE;
      default:  state_d = E_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the FSM.
  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      state_q       <= E_IDLE;
      consumer_q    <= 1'b0;
      start_valid_q <= 1'b0;
      start_group_q <= 1'b0;
      op_en_clr_q   <= 2'b00;
      done_intr_q   <= 2'b00;
      err_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      consumer_q    <= finish_s ? ~consumer_q : consumer_q;
      start_valid_q <= (state_d == E_LAUNCH);
      start_group_q <= (state_d == E_LAUNCH) ? consumer_q : start_group_q;
      op_en_clr_q   <= finish_s ? grp_sel_s : 2'b00;
      done_intr_q   <= finish_s ? grp_sel_s : 2'b00;
      err_busy_q    <= |busy_wr_s;
    end
  end

`ifdef AUTOSA_PDP_RDMA_PERF_EN
  logic [PERF_W-1:0] cnt_q, perf_q;

  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      if (launch_s) begin
        cnt_q <= '0;
      end else if ((state_q == E_BUSY) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end
      if (finish_s) begin
        perf_q <= cnt_q;
      end
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign consumer    = consumer_q;
  assign status_0    = grp_status_s[0];
  assign status_1    = grp_status_s[1];
  assign start_valid = start_valid_q;
  assign start_group = start_group_q;
  assign op_en_clr   = op_en_clr_q;
  assign done_intr   = done_intr_q;
  assign err_busy_wr = err_busy_q;

endmodule
